// File: rtl/fb_pkg.sv
// fb_pkg: definitions shared by the frame-buffer writers and the scanout reader.
//   Screen geometry defaults, address and pixel widths, and the scanout FSM
//   state type.
`timescale 1ns/1ps
package fb_pkg;

  localparam int unsigned DEF_SCREEN_WIDTH  = 640;
  localparam int unsigned DEF_SCREEN_HEIGHT = 480;
  localparam int unsigned ADDR_W            = 24;  // {bank[1:0], pixel offset[21:0]}
  localparam int unsigned RGB_W             = 16;  // RGB565

  typedef enum logic [2:0] {
    SCAN_IDLE,
    SCAN_WAIT_SPACE,
    SCAN_BURST,
    SCAN_ADVANCE,
    SCAN_DONE
  } scan_state_e;

endpackage

// File: rtl/scanout_line_fifo.sv
// scanout_line_fifo: synchronous pixel FIFO for the scanout reader.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the FIFO; takes priority over push
//   push, din  : write one word
//   pop        : read one word into dout (registered); popping an empty FIFO
//                loads zero into dout
//   empty      : no words stored
//   free       : number of free entries (0..DEPTH)
`timescale 1ns/1ps
module scanout_line_fifo #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;

  assign empty  = (count == '0);
  assign free   = (AW+1)'(DEPTH) - count;
  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (pop) dout <= empty ? '0 : mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + AW'(1);
        if (do_pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
      end
    end
  end

endmodule

// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: frame-buffer scanout client.
//   Reads the active SDRAM bank in raster order with line-bounded burst reads,
//   buffers words in scanout_line_fifo, and hands one pixel per pixel_req to
//   the VGA stage.
//   clk, rst                  : clock, synchronous active-high reset
//   enable, frame_start, bank : scanout control from VGA timing
//   read_burst_req/addr/len   : burst request to the SDRAM arbiter (held until finish)
//   read_burst_data_valid/data/finish : burst read return path
//   pixel_req                 : VGA pop; pixel_rgb/pixel_valid one cycle later
//   underflow                 : sticky, pop on empty FIFO since last accepted frame_start
//   frame_done                : one-cycle pulse after the last burst of a frame
// Build option SCANOUT_BANK_LATCH_EN: when defined, bank is captured at each
// accepted frame_start and used for the whole frame; otherwise the live bank
// is sampled at the start of every burst.
`timescale 1ns/1ps
module fb_scanout_reader
  import fb_pkg::*;
#(
  parameter int unsigned BURST_BITS         = 10,
  parameter int unsigned SCREEN_WIDTH       = DEF_SCREEN_WIDTH,
  parameter int unsigned SCREEN_HEIGHT      = DEF_SCREEN_HEIGHT,
  parameter int unsigned MAX_READ_BURST_LEN = 128,
  parameter int unsigned BIT_SIZE           = 10,
  parameter int unsigned FIFO_DEPTH         = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic [1:0]            bank,
  output logic                  read_burst_req,
  output logic [ADDR_W-1:0]     read_addr,
  output logic [BURST_BITS-1:0] read_burst_len,
  input  logic                  read_burst_data_valid,
  input  logic [RGB_W-1:0]      read_burst_data,
  input  logic                  read_burst_finish,
  input  logic                  pixel_req,
  output logic [RGB_W-1:0]      pixel_rgb,
  output logic                  pixel_valid,
  output logic                  underflow,
  output logic                  frame_done
);

  localparam logic [BIT_SIZE:0]   LINE_W  = (BIT_SIZE+1)'(SCREEN_WIDTH);
  localparam logic [BIT_SIZE:0]   MAX_EXT = (BIT_SIZE+1)'(MAX_READ_BURST_LEN);
  localparam logic [BIT_SIZE-1:0] LAST_Y  = BIT_SIZE'(SCREEN_HEIGHT - 1);

  scan_state_e state, state_n;

  logic [BIT_SIZE-1:0]        x, y;
  logic                       pending;
  logic                       accept, restart, start_burst, advance, burst_exit;
  logic [BIT_SIZE:0]          remaining, x_sum;
  logic [BURST_BITS-1:0]      len_now;
  logic                       fits, line_end, last_burst;
  logic [ADDR_W-3:0]          pix_off;
  logic [1:0]                 bank_sel;
  logic                       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_free;

`ifdef SCANOUT_BANK_LATCH_EN
  logic [1:0] bank_lat;
  always_ff @(posedge clk) begin
    if (rst)         bank_lat <= '0;
    else if (accept) bank_lat <= bank;
  end
  assign bank_sel = bank_lat;
`else
  assign bank_sel = bank;
`endif

  scanout_line_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RGB_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (restart),
    .push  (read_burst_data_valid && (state == SCAN_BURST)),
    .din   (read_burst_data),
    .pop   (pixel_req),
    .dout  (pixel_rgb),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

  always_comb begin
    accept     = frame_start && enable;
    remaining  = LINE_W - {1'b0, x};
    len_now    = (remaining > MAX_EXT) ? BURST_BITS'(MAX_READ_BURST_LEN)
                                       : BURST_BITS'(remaining);
    fits       = 32'(fifo_free) >= 32'(len_now);
    x_sum      = {1'b0, x} + (BIT_SIZE+1)'(read_burst_len);
    line_end   = (x_sum == LINE_W);
    last_burst = line_end && (y == LAST_Y);
    pix_off    = (ADDR_W-2)'(y) * (ADDR_W-2)'(SCREEN_WIDTH) + (ADDR_W-2)'(x);
  end

  always_comb begin
    state_n     = state;
    restart     = 1'b0;
    start_burst = 1'b0;
    advance     = 1'b0;
    case (state)
      SCAN_IDLE: begin
        if (accept) begin
          restart = 1'b1;
          state_n = SCAN_WAIT_SPACE;
        end
      end
      SCAN_WAIT_SPACE: begin
        if (accept) begin
          restart = 1'b1;
        end else if (!enable) begin
          state_n = SCAN_IDLE;
        end else if (fits) begin
          start_burst = 1'b1;
          state_n     = SCAN_BURST;
        end
      end
      SCAN_BURST: begin
        // A frame_start seen during the burst (or with finish) restarts only
        // once the controller has completed the burst; the flush then drops
        // whatever this burst pushed.
        if (read_burst_finish) begin
          if (!enable) begin
            state_n = SCAN_IDLE;
          end else if (pending || accept) begin
            restart = 1'b1;
            state_n = SCAN_WAIT_SPACE;
          end else begin
            state_n = SCAN_ADVANCE;
          end
        end
      end
      SCAN_ADVANCE: begin
        if (accept) begin
          restart = 1'b1;
          state_n = SCAN_WAIT_SPACE;
        end else if (!enable) begin
          state_n = SCAN_IDLE;
        end else begin
          advance = 1'b1;
          state_n = last_burst ? SCAN_DONE : SCAN_WAIT_SPACE;
        end
      end
      SCAN_DONE: begin
        if (accept) begin
          restart = 1'b1;
          state_n = SCAN_WAIT_SPACE;
        end else begin
          state_n = SCAN_IDLE;
        end
      end
      default: state_n = SCAN_IDLE;
    endcase
    burst_exit = (state == SCAN_BURST) && (state_n != SCAN_BURST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= SCAN_IDLE;
      x              <= '0;
      y              <= '0;
      pending        <= 1'b0;
      read_burst_req <= 1'b0;
      read_addr      <= '0;
      read_burst_len <= '0;
      pixel_valid    <= 1'b0;
      underflow      <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state       <= state_n;
      frame_done  <= (state == SCAN_DONE);
      pixel_valid <= pixel_req;
      if (accept)                  underflow <= 1'b0;
      if (pixel_req && fifo_empty) underflow <= 1'b1;

      if (restart) begin
        x <= '0;
        y <= '0;
      end else if (advance) begin
        x <= line_end ? '0 : x_sum[BIT_SIZE-1:0];
        if (line_end) y <= y + BIT_SIZE'(1);
      end

      if (burst_exit)                          pending <= 1'b0;
      else if (state == SCAN_BURST && accept)  pending <= 1'b1;

      if (start_burst) begin
        read_burst_req <= 1'b1;
        read_addr      <= {bank_sel, pix_off};
        read_burst_len <= len_now;
      end else if (burst_exit) begin
        read_burst_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Self-checking bench for fb_scanout_reader with a zero-wait SDRAM controller
// model, a pixel scoreboard and a table of expected burst addresses.
// Geometry is reduced (200x6) so a full frame fits a short run; 200 wide gives
// per-line bursts of 128 then 72.
`timescale 1ns/1ps
module tb_fb_scanout_reader;

  localparam int W = 200;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst, enable, frame_start, pixel_req;
  logic [1:0]  bank;
  logic        read_burst_req, read_burst_data_valid, read_burst_finish;
  logic [23:0] read_addr;
  logic [9:0]  read_burst_len;
  logic [15:0] read_burst_data, pixel_rgb;
  logic        pixel_valid, underflow, frame_done;

  always #5 clk = ~clk;

  fb_scanout_reader #(
    .BURST_BITS         (10),
    .SCREEN_WIDTH       (W),
    .SCREEN_HEIGHT      (H),
    .MAX_READ_BURST_LEN (128),
    .BIT_SIZE           (10),
    .FIFO_DEPTH         (512)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .frame_start           (frame_start),
    .bank                  (bank),
    .read_burst_req        (read_burst_req),
    .read_addr             (read_addr),
    .read_burst_len        (read_burst_len),
    .read_burst_data_valid (read_burst_data_valid),
    .read_burst_data       (read_burst_data),
    .read_burst_finish     (read_burst_finish),
    .pixel_req             (pixel_req),
    .pixel_rgb             (pixel_rgb),
    .pixel_valid           (pixel_valid),
    .underflow             (underflow),
    .frame_done            (frame_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int fd_count = 0;
  int data_idx = 0;
  logic [15:0] salt_next = 16'h0000;
  logic [15:0] exp_q [$];
  logic [23:0] b_addr [$];
  logic [9:0]  b_len [$];

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    return a[15:0] ^ {a[23:22], 6'h15, a[21:14]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout, got no event expected event", nm);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_bursts(input int target, input string nm);
    int t = 0;
    while (b_addr.size() < target && t < 3000) begin tick(1); t++; end
    if (b_addr.size() < target) timeout_fail(nm);
  endtask

  task automatic wait_req_low(input string nm);
    int t = 0;
    while (read_burst_req && t < 400) begin tick(1); t++; end
    if (read_burst_req) timeout_fail(nm);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  // Zero-wait controller: streams len words right after seeing a request.
  logic [23:0] m_addr;
  logic [9:0]  m_len;
  logic [15:0] m_salt;
  initial begin
    read_burst_data_valid = 1'b0;
    read_burst_data       = '0;
    read_burst_finish     = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (read_burst_req && !rst) begin
        m_addr = read_addr;
        m_len  = read_burst_len;
        m_salt = salt_next;
        b_addr.push_back(m_addr);
        b_len.push_back(m_len);
        for (int i = 0; i < int'(m_len); i++) begin
          read_burst_data_valid = 1'b1;
          read_burst_data       = mem_word(m_addr + 24'(i)) ^ m_salt;
          data_idx              = i + 1;
          @(posedge clk); #1;
        end
        read_burst_data_valid = 1'b0;
        read_burst_finish     = 1'b1;
        data_idx              = 0;
        @(posedge clk); #1;
        read_burst_finish     = 1'b0;
      end
    end
  end

  logic [15:0] mon_exp;
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd_count++;
      if (pixel_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pixel_extra: got %0h expected no pixel", pixel_rgb);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("pixel_rgb", {16'h0, pixel_rgb}, {16'h0, mon_exp});
        end
      end
    end
  end

  typedef struct {
    int          idx;
    logic [23:0] addr;
    logic [9:0]  len;
  } burst_vec_t;
  burst_vec_t tbl [6];

  int          base, t;
  int          k;
  logic [1:0]  exp_bank;

  initial begin
    tbl[0] = '{0,  24'h400000, 10'd128};
    tbl[1] = '{1,  24'h400080, 10'd72};
    tbl[2] = '{2,  24'h4000C8, 10'd128};
    tbl[3] = '{3,  24'h400148, 10'd72};
    tbl[4] = '{10, 24'h4003E8, 10'd128};
    tbl[5] = '{11, 24'h400468, 10'd72};

    rst = 1'b1; enable = 1'b0; frame_start = 1'b0; pixel_req = 1'b0; bank = 2'b00;
    tick(4);
    rst = 1'b0;
    tick(1);

    // Reset state
    chk("rst_req",       {31'h0, read_burst_req}, 32'h0);
    chk("rst_addr",      {8'h0, read_addr},       32'h0);
    chk("rst_len",       {22'h0, read_burst_len}, 32'h0);
    chk("rst_rgb",       {16'h0, pixel_rgb},      32'h0);
    chk("rst_valid",     {31'h0, pixel_valid},    32'h0);
    chk("rst_underflow", {31'h0, underflow},      32'h0);
    chk("rst_frame_done",{31'h0, frame_done},     32'h0);

    // First request two cycles after frame_start
    enable = 1'b1; bank = 2'b01;
    pulse_frame_start();
    chk("req_at_1", {31'h0, read_burst_req}, 32'h0);
    tick(1);
    chk("req_at_2",  {31'h0, read_burst_req}, 32'h1);
    chk("addr_at_2", {8'h0, read_addr},       32'h400000);
    chk("len_at_2",  {22'h0, read_burst_len}, 32'd128);

    // Full frame with line blanking between 200-pixel lines
    tick(30);
    k = 0;
    for (int ln = 0; ln < H; ln++) begin
      for (int p = 0; p < W; p++) begin
        pixel_req = 1'b1;
        exp_q.push_back(mem_word({2'b01, 22'(k)}));
        k++;
        tick(1);
      end
      pixel_req = 1'b0;
      tick(40);
    end
    t = 0;
    while (fd_count == 0 && t < 5000) begin tick(1); t++; end
    if (fd_count == 0) timeout_fail("frame_done_wait");
    tick(10);
    chk("frame_done_count", fd_count,            32'd1);
    chk("frame_underflow",  {31'h0, underflow},  32'h0);
    chk("frame_pix_left",   exp_q.size(),        32'h0);
    chk("frame_bursts",     b_addr.size(),       32'd12);
    chk("idle_req",         {31'h0, read_burst_req}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].idx < b_addr.size()) begin
        chk($sformatf("burst%0d_addr", tbl[i].idx), {8'h0, b_addr[tbl[i].idx]}, {8'h0, tbl[i].addr});
        chk($sformatf("burst%0d_len", tbl[i].idx),  {22'h0, b_len[tbl[i].idx]}, {22'h0, tbl[i].len});
      end else begin
        timeout_fail($sformatf("burst%0d_missing", tbl[i].idx));
      end
    end

    // Three pops on an empty FIFO
    for (int i = 0; i < 3; i++) begin
      pixel_req = 1'b1;
      exp_q.push_back(16'h0000);
      tick(1);
    end
    pixel_req = 1'b0;
    tick(2);
    chk("underflow_set",  {31'h0, underflow}, 32'h1);
    chk("empty_pix_left", exp_q.size(),       32'h0);
    tick(10);
    chk("underflow_held", {31'h0, underflow}, 32'h1);

    // frame_start on the 10th data word of a burst
    base = b_addr.size();
    pulse_frame_start();
    chk("underflow_cleared", {31'h0, underflow}, 32'h0);
    t = 0;
    while (!(b_addr.size() == base + 1 && data_idx == 10) && t < 200) begin tick(1); t++; end
    if (!(b_addr.size() == base + 1 && data_idx == 10)) timeout_fail("data10_wait");
    salt_next = 16'h5A5A;
    pulse_frame_start();
    wait_bursts(base + 2, "restart_burst_wait");
    if (b_addr.size() >= base + 2) begin
      chk("restart_addr", {8'h0, b_addr[base+1]}, 32'h400000);
      chk("restart_len",  {22'h0, b_len[base+1]}, 32'd128);
    end
    tick(140);
    for (int i = 0; i < 5; i++) begin
      pixel_req = 1'b1;
      exp_q.push_back(mem_word(24'h400000 + 24'(i)) ^ 16'h5A5A);
      tick(1);
    end
    pixel_req = 1'b0;
    tick(3);
    chk("restart_pix_left", exp_q.size(), 32'h0);

    // enable low: finish current burst, stay idle, ignore frame_start
    enable = 1'b0;
    wait_req_low("disable_wait");
    tick(10);
    chk("disabled_idle", {31'h0, read_burst_req}, 32'h0);
    pulse_frame_start();
    tick(5);
    chk("disabled_ignore_fs", {31'h0, read_burst_req}, 32'h0);

    // Bank change mid-frame
    salt_next = 16'h0000;
    enable = 1'b1; bank = 2'b01;
    base = b_addr.size();
    pulse_frame_start();
    wait_bursts(base + 1, "bank_burst1_wait");
    bank = 2'b10;
    wait_bursts(base + 2, "bank_burst2_wait");
`ifdef SCANOUT_BANK_LATCH_EN
    exp_bank = 2'b01;
`else
    exp_bank = 2'b10;
`endif
    if (b_addr.size() >= base + 2) begin
      chk("bank_burst1_addr", {8'h0, b_addr[base]},   32'h400000);
      chk("bank_burst2_addr", {8'h0, b_addr[base+1]}, {8'h0, exp_bank, 22'h80});
    end

    // Reset in the middle of a burst withdraws the request next cycle
    tick(20);
    chk("pre_reset_req", {31'h0, read_burst_req}, 32'h1);
    rst = 1'b1;
    tick(1);
    chk("reset_drop_req", {31'h0, read_burst_req}, 32'h0);
    rst = 1'b0;
    tick(200);
    chk("post_reset_req", {31'h0, read_burst_req}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fb_scanout_reader.md
# fb_scanout_reader

Frame-buffer scanout client. It reads the active bank of SDRAM in raster order using burst reads and buffers the pixels in an internal FIFO. The VGA timing generator pops them one per pixel clock. It is the read-side counterpart of the rectangle/blit writers and sits between the SDRAM burst arbiter's read port and the VGA output stage.

## Interface
- BURST_BITS, 10, width of burst length field
- SCREEN_WIDTH, 640, pixels per line
- SCREEN_HEIGHT, 480, lines per frame
- MAX_READ_BURST_LEN, 128, longest burst issued
- BIT_SIZE, 10, width of x/y counters
- FIFO_DEPTH, 512, pixel FIFO entries (power of two, ≥ 2×MAX_READ_BURST_LEN)
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- enable  in  1  scanout allowed; low holds the FSM in IDLE after the current burst
- frame_start  in  1  one-cycle pulse from VGA timing at start of vertical blank
- bank  in  2  frame-buffer bank to read
- read_burst_req  out  1  burst request; held until read_burst_finish
- read_addr  out  24  {bank, y*SCREEN_WIDTH + x}; stable while read_burst_req is high
- read_burst_len  out  BURST_BITS  words in the current burst
- read_burst_data_valid  in  1  one data word present on read_burst_data
- read_burst_data  in  16  RGB565 word
- read_burst_finish  in  1  one-cycle pulse after the last data word of a burst
- pixel_req  in  1  VGA pops one pixel
- pixel_rgb  out  16  popped pixel; 16'h0000 on underflow
- pixel_valid  out  1  pixel_rgb updated this cycle
- underflow  out  1  sticky; a pop hit an empty FIFO this frame
- frame_done  out  1  one-cycle pulse when the last burst of a frame completes

## Operation
- FSM states: IDLE, WAIT_SPACE, BURST, ADVANCE, DONE.
- IDLE:
  - On frame_start with enable=1: flush the FIFO, set x=y=0, clear underflow, go to WAIT_SPACE.
- WAIT_SPACE:
  - len = min(SCREEN_WIDTH − x, MAX_READ_BURST_LEN).
  - Go to BURST when FIFO free entries ≥ len.
- BURST:
  - read_burst_req=1, with read_addr and read_burst_len registered on entry.
  - Each read_burst_data_valid pushes one word.
  - read_burst_finish moves to ADVANCE.
- ADVANCE:
  - x += len. If x == SCREEN_WIDTH, then x=0 and y += 1.
  - If y == SCREEN_HEIGHT, go to DONE; otherwise go to WAIT_SPACE.
  - Bursts never cross a line boundary. At 640 wide, a line is 5 bursts of 128.
- DONE:
  - Pulse frame_done for one cycle, then go to IDLE.
- Address arithmetic:
  - Uses 22-bit y*SCREEN_WIDTH + x, zero-extended. No wrap is possible inside valid geometry.
- Pop path:
  - pixel_req with FIFO non-empty: read one word into pixel_rgb.
  - pixel_req with FIFO empty: pixel_rgb=0 and underflow set (sticky until the next accepted frame_start).
- Overflow cannot occur because of the free-space check.
- Boundary conditions:
  - frame_start during BURST: latch a pending restart. Finish the burst; the data is pushed, then discarded by the flush. Then restart at (0,0).
  - frame_start in WAIT_SPACE/ADVANCE/DONE: restart immediately (flush, x=y=0).
  - frame_start and read_burst_finish in the same cycle: treated as frame_start during BURST.
  - enable low: the current burst completes, then the FSM goes to IDLE. frame_start is ignored while enable=0.
  - pixel_req concurrent with a push: both occur; the occupancy count is unchanged.
  - Reset mid-burst: read_burst_req drops in the next cycle. The controller tolerates a withdrawn request.

## Timing
- Reset values:
  - read_burst_req=0, read_addr=0, read_burst_len=0, pixel_rgb=0.
  - pixel_valid=0, underflow=0, frame_done=0.
  - FSM=IDLE, FIFO empty.
- frame_start → read_burst_req: 2 cycles (IDLE→WAIT_SPACE→BURST) when the FIFO is empty.
- pixel_req → pixel_valid/pixel_rgb: 1 cycle, registered.
- read_burst_data_valid → word poppable: 1 cycle.
- read_burst_finish → next read_burst_req: minimum 2 cycles (ADVANCE, WAIT_SPACE).
- frame_done: one cycle, 1 cycle after entering DONE.

## Configuration
- SCANOUT_BANK_LATCH_EN defined: bank is sampled only at an accepted frame_start and used for the whole frame (tear-free double buffering).
- SCANOUT_BANK_LATCH_EN undefined: live bank is sampled on entry to BURST for each burst.

## Structure
- Package fb_pkg holds:
  - SCREEN_WIDTH/HEIGHT defaults, ADDR_W=24, RGB_W=16.
  - Scanout state enum.
  - Shared between writers and this reader.
- Sub-module scanout_line_fifo:
  - Synchronous FIFO with DEPTH parameter.
  - push, pop, dout registered, empty, free count output.

## Test plan
- Reset, then frame_start, enable=1, bank=2'b01, FIFO empty → read_burst_req at +2 cycles, read_addr=24'h400000, read_burst_len=128.
- Full frame with a zero-wait controller model and VGA popping 640 per line with blanking → 2400 bursts, last read_addr={bank, 479*640+512}, frame_done once, underflow=0, pixel data matches the memory model.
- SCREEN_WIDTH=200, MAX=128 → per-line bursts of 128 then 72; the second read_addr offset is +128.
- Pop 3 pixels with FIFO empty → pixel_rgb=0 each, underflow=1 and held until the next frame_start.
- frame_start in the 10th data cycle of a burst → burst completes, FIFO flushed, next read_addr offset 0, no stale pixel popped.
- With SCANOUT_BANK_LATCH_EN: change bank mid-frame → all addresses keep the original bank. Without it: the next burst uses the new bank.
